// File: rtl/mem_bus_pkg.sv
// Shared types and default parameter values for the CPU-to-slave memory bus controller.
package mem_bus_pkg;

    localparam int DEF_DW       = 32;
    localparam int DEF_AW       = 16;
    localparam int DEF_SEL_BITS = 2;
    localparam int DEF_N_SLAVES = 3;
    localparam int DEF_TIMEOUT  = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_bus_decode.sv
// Combinational address decoder: splits a virtual address into a region index,
// a one-hot channel select, a mapped/unmapped flag and the physical offset.
module mem_bus_decode
    import mem_bus_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int SEL_BITS = DEF_SEL_BITS,
    parameter int N_SLAVES = DEF_N_SLAVES
) (
    input  logic [AW-1:0]       addr,
    output logic [SEL_BITS-1:0] region,
    output logic [N_SLAVES-1:0] sel,
    output logic                valid,
    output logic [AW-1:0]       offset
);

    assign region = addr[AW-1 -: SEL_BITS];
    assign valid  = (int'(region) < N_SLAVES);
    assign offset = {{SEL_BITS{1'b0}}, addr[AW-SEL_BITS-1:0]};

    generate
        for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_sel
            assign sel[gi] = (region == SEL_BITS'(gi));
        end
    endgenerate

endmodule

// File: rtl/mem_bus_ctrl.sv
// Single-master memory bus controller: IDLE -> ACCESS -> RESP handshake towards
// N_SLAVES channels. Define MEM_BUS_TIMEOUT_EN to abort ACCESS after TIMEOUT cycles.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int AW       = DEF_AW,
    parameter int SEL_BITS = DEF_SEL_BITS,
    parameter int N_SLAVES = DEF_N_SLAVES,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req,
    input  logic                   we,
    input  logic [AW-1:0]          addr,
    input  logic [DW-1:0]          wdata,
    output logic [DW-1:0]          rdata,
    output logic                   ready,
    output logic                   err,
    output logic [N_SLAVES-1:0]    s_sel,
    output logic [AW-1:0]          s_addr,
    output logic [DW-1:0]          s_wdata,
    output logic                   s_we,
    input  logic [N_SLAVES*DW-1:0] s_rdata,
    input  logic [N_SLAVES-1:0]    s_ready
);

    if (N_SLAVES < 1 || N_SLAVES > 2**SEL_BITS || TIMEOUT < 1) begin : g_bad_params
        $error("mem_bus_ctrl: illegal N_SLAVES/SEL_BITS/TIMEOUT combination");
    end

    state_t                state_reg, state_next;
    logic [N_SLAVES-1:0]   sel_reg;
    logic [AW-1:0]         addr_reg;
    logic [DW-1:0]         wdata_reg;
    logic [DW-1:0]         rdata_reg;
    logic                  we_reg;
    logic                  err_reg;

    logic [SEL_BITS-1:0]   dec_region;
    logic [N_SLAVES-1:0]   dec_sel;
    logic                  dec_valid;
    logic [AW-1:0]         dec_offset;
    logic                  sel_ready;
    logic [DW-1:0]         sel_rdata;
    logic                  tmo_hit;

    mem_bus_decode #(
        .AW       (AW),
        .SEL_BITS (SEL_BITS),
        .N_SLAVES (N_SLAVES)
    ) u_decode (
        .addr   (addr),
        .region (dec_region),
        .sel    (dec_sel),
        .valid  (dec_valid),
        .offset (dec_offset)
    );

    // Only the latched channel can complete the access; other s_ready bits are masked off.
    assign sel_ready = |(s_ready & sel_reg);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_reg[i]) sel_rdata = sel_rdata | s_rdata[i*DW +: DW];
        end
    end

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt_reg;

    // Holds the number of ACCESS cycles already completed; hit on the TIMEOUT-th one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt_reg <= '0;
        else if (state_reg == ACCESS && state_next == ACCESS)
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        else
            tmo_cnt_reg <= '0;
    end

    assign tmo_hit = (state_reg == ACCESS) && (tmo_cnt_reg == CW'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req) state_next = dec_valid ? ACCESS : RESP;
            ACCESS:  if (sel_ready || tmo_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            sel_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            we_reg    <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: if (req) begin
                    sel_reg   <= dec_sel;
                    addr_reg  <= dec_offset;
                    wdata_reg <= wdata;
                    we_reg    <= we;
                    err_reg   <= !dec_valid;
                    if (!dec_valid) rdata_reg <= '0;
                end
                // A completing slave wins over a simultaneous timeout.
                ACCESS: if (sel_ready) begin
                    err_reg <= 1'b0;
                    if (!we_reg) rdata_reg <= sel_rdata;
                end else if (tmo_hit) begin
                    err_reg   <= 1'b1;
                    rdata_reg <= '0;
                end
                default: ;
            endcase
        end
    end

    assign ready   = (state_reg == RESP);
    assign err     = (state_reg == RESP) && err_reg;
    assign rdata   = rdata_reg;
    assign s_sel   = (state_reg == ACCESS) ? sel_reg : '0;
    assign s_we    = (state_reg == ACCESS) && we_reg;
    assign s_addr  = addr_reg;
    assign s_wdata = wdata_reg;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: expected responses are queued at request time
// and popped when ready pulses. Timeout scenarios follow MEM_BUS_TIMEOUT_EN.
module tb_mem_bus_ctrl;

    localparam int DW       = 32;
    localparam int AW       = 16;
    localparam int SEL_BITS = 2;
    localparam int N_SLAVES = 3;
    localparam int TIMEOUT  = 15;
`ifdef MEM_BUS_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   req = 1'b0;
    logic                   we = 1'b0;
    logic [AW-1:0]          addr = '0;
    logic [DW-1:0]          wdata = '0;
    logic [DW-1:0]          rdata;
    logic                   ready;
    logic                   err;
    logic [N_SLAVES-1:0]    s_sel;
    logic [AW-1:0]          s_addr;
    logic [DW-1:0]          s_wdata;
    logic                   s_we;
    logic [N_SLAVES*DW-1:0] s_rdata = '0;
    logic [N_SLAVES-1:0]    s_ready = '0;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model_rdata = '0;
    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 clk = ~clk;

    mem_bus_ctrl #(
        .DW(DW), .AW(AW), .SEL_BITS(SEL_BITS), .N_SLAVES(N_SLAVES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .err(err), .s_sel(s_sel), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_we(s_we), .s_rdata(s_rdata), .s_ready(s_ready)
    );

    // One transfer: slave answers after 'waits' wait cycles (large = never).
    task automatic run_xfer(input string name, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input int waits,
                            input logic [DW-1:0] srd, input bit junk);
        int                  region;
        bit                  valid;
        logic [N_SLAVES-1:0] esel;
        logic [AW-1:0]       eaddr;
        exp_t                e;
        exp_t                got;
        int                  cyc;
        bit                  done;
        region = int'(a[AW-1 -: SEL_BITS]);
        valid  = region < N_SLAVES;
        esel   = valid ? N_SLAVES'(1 << region) : '0;
        eaddr  = {{SEL_BITS{1'b0}}, a[AW-SEL_BITS-1:0]};
        if (!valid) begin
            e.rdata = '0; e.err = 1'b1; e.lat = 1;
        end else if (TMO_EN && waits + 1 > TIMEOUT) begin
            e.rdata = '0; e.err = 1'b1; e.lat = TIMEOUT + 1;
        end else begin
            e.rdata = w ? model_rdata : srd; e.err = 1'b0; e.lat = waits + 2;
        end
        model_rdata = e.rdata;
        exp_q.push_back(e);

        s_rdata = {N_SLAVES{32'hBAD0_BAD0}};
        if (valid) s_rdata[region*DW +: DW] = srd;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = wd;
        s_ready = junk ? ~esel : '0;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                req = 1'b0; we = ~w; addr = ~a; wdata = ~wd;
            end
            if (ready) begin
                got = exp_q.pop_front();
                done = 1'b1;
                n_tests++;
                if (rdata !== got.rdata) begin
                    n_fail++;
                    $display("FAIL %s rdata: got %h expected %h", name, rdata, got.rdata);
                end
                n_tests++;
                if (err !== got.err) begin
                    n_fail++;
                    $display("FAIL %s err: got %b expected %b", name, err, got.err);
                end
                n_tests++;
                if (cyc !== got.lat) begin
                    n_fail++;
                    $display("FAIL %s latency: got %0d expected %0d", name, cyc, got.lat);
                end
                n_tests++;
                if (s_sel !== '0) begin
                    n_fail++;
                    $display("FAIL %s s_sel_in_resp: got %b expected 0", name, s_sel);
                end
            end else begin
                n_tests++;
                if ({s_sel, s_addr, s_we, s_wdata} !== {esel, eaddr, w, wd}) begin
                    n_fail++;
                    $display("FAIL %s access_cyc%0d: got sel=%b addr=%h we=%b wdata=%h expected sel=%b addr=%h we=%b wdata=%h",
                             name, cyc, s_sel, s_addr, s_we, s_wdata, esel, eaddr, w, wd);
                end
                s_ready = (junk ? ~esel : '0) | ((cyc == waits + 1) ? esel : '0);
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s no_ready: got none in %0d cycles expected latency %0d", name, cyc, e.lat);
            exp_q.delete();
        end
        s_ready = '0;
        @(negedge clk);
        n_tests++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ready_pulse_width: got ready=%b expected 0", name, ready);
        end
        $display("[TB] xfer %s we=%b addr=%h -> rdata=%h err=%b", name, w, a, rdata, err);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({ready, err, rdata, s_sel, s_we, s_addr, s_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b err=%b rdata=%h sel=%b we=%b addr=%h wdata=%h expected all 0",
                     ready, err, rdata, s_sel, s_we, s_addr, s_wdata);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (ready !== 1'b0 || s_sel !== '0) begin
            n_fail++;
            $display("FAIL reset_release: got ready=%b sel=%b expected 0", ready, s_sel);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_read();
        run_xfer("read_8004", 1'b0, 16'h8004, 32'h0, 0, 32'hDEAD_BEEF, 1'b1);
    endtask

    task automatic test_write();
        run_xfer("write_4010", 1'b1, 16'h4010, 32'h1234_5678, 3, 32'h5555_AAAA, 1'b1);
        run_xfer("write_r0", 1'b1, 16'h0ABC, 32'hA5A5_0F0F, 1, 32'h0, 1'b0);
    endtask

    task automatic test_unmapped();
        run_xfer("unmapped_c000", 1'b0, 16'hC000, 32'h0, 0, 32'h7777_7777, 1'b1);
        run_xfer("read_r1_after_err", 1'b0, 16'h7FFC, 32'h0, 2, 32'h0BAD_F00D, 1'b1);
    endtask

    task automatic test_timeout();
        if (TMO_EN) begin
            run_xfer("tmo_abort", 1'b0, 16'h0030, 32'h0, 1000, 32'h1111_2222, 1'b1);
            run_xfer("tmo_edge_ready", 1'b0, 16'h0034, 32'h0, TIMEOUT - 1, 32'hCAFE_F00D, 1'b0);
        end else begin
            run_xfer("long_wait", 1'b0, 16'h0030, 32'h0, 30, 32'h1111_2222, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        exp_t got;
        exp_t e;
        int   cyc;
        int   nready;
        s_rdata = {32'hC2C2_C2C2, 32'hC1C1_C1C1, 32'hC0C0_C0C0};
        e.rdata = 32'hC0C0_C0C0; e.err = 1'b0; e.lat = 2;
        exp_q.push_back(e);
        e.rdata = 32'hC1C1_C1C1; e.err = 1'b0; e.lat = 5;
        exp_q.push_back(e);
        model_rdata = 32'hC1C1_C1C1;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 16'h0008; s_ready = '1;
        cyc = 0;
        nready = 0;
        while (nready < 2 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (ready && exp_q.size() > 0) begin
                got = exp_q.pop_front();
                nready++;
                n_tests++;
                if (rdata !== got.rdata || cyc !== got.lat) begin
                    n_fail++;
                    $display("FAIL b2b_%0d: got rdata=%h cycle=%0d expected rdata=%h cycle=%0d",
                             nready, rdata, cyc, got.rdata, got.lat);
                end
                if (nready == 1) addr = 16'h4008;
                if (nready == 2) req = 1'b0;
            end
        end
        if (nready < 2) begin
            n_tests++;
            n_fail++;
            $display("FAIL b2b_count: got %0d ready pulses expected 2", nready);
            exp_q.delete();
        end
        req = 1'b0;
        s_ready = '0;
        @(negedge clk);
        $display("[TB] back_to_back done, %0d responses", nready);
    endtask

    task automatic test_reset_mid_access();
        bit saw_ready;
        s_rdata = {32'h0, 32'h0, 32'h4444_4444};
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 16'h0020; wdata = 32'h9999_8888;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        n_tests++;
        if (s_sel !== 3'b001 || s_we !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_in_access: got sel=%b we=%b expected sel=001 we=1", s_sel, s_we);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({ready, err, rdata, s_sel, s_we, s_addr, s_wdata} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got ready=%b err=%b rdata=%h sel=%b we=%b addr=%h wdata=%h expected all 0",
                     ready, err, rdata, s_sel, s_we, s_addr, s_wdata);
        end
        model_rdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        s_ready = '1;
        saw_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ready) saw_ready = 1'b1;
        end
        s_ready = '0;
        n_tests++;
        if (saw_ready) begin
            n_fail++;
            $display("FAIL rst_mid_no_ready: got a ready pulse expected none");
        end
        $display("[TB] reset during access checked");
        run_xfer("read_after_rst", 1'b0, 16'h4100, 32'h0, 1, 32'h3141_5926, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_unmapped();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
